// File: rtl/input_mapper_pkg.sv
// Shared constants and types for the player-input front end: PS/2 scancode map,
// held-key record layout and hps_io joystick bit positions.
package input_mapper_pkg;

    localparam int KBD_PLAYERS  = 2;
    localparam int KBD_BUTTONS  = 3;
    localparam int JOY_BTN_BASE = 4;

    localparam logic [7:0] SC_P1_UP    = 8'h75;
    localparam logic [7:0] SC_P1_DOWN  = 8'h72;
    localparam logic [7:0] SC_P1_LEFT  = 8'h6B;
    localparam logic [7:0] SC_P1_RIGHT = 8'h74;
    localparam logic [7:0] SC_P1_BTN1  = 8'h14;
    localparam logic [7:0] SC_P1_BTN2  = 8'h11;
    localparam logic [7:0] SC_P1_BTN3  = 8'h29;
    localparam logic [7:0] SC_P1_START = 8'h16;
    localparam logic [7:0] SC_P1_COIN  = 8'h2E;
    localparam logic [7:0] SC_P1_PAUSE = 8'h4D;

    localparam logic [7:0] SC_P2_UP    = 8'h2D;
    localparam logic [7:0] SC_P2_DOWN  = 8'h2B;
    localparam logic [7:0] SC_P2_LEFT  = 8'h23;
    localparam logic [7:0] SC_P2_RIGHT = 8'h34;
    localparam logic [7:0] SC_P2_BTN1  = 8'h1C;
    localparam logic [7:0] SC_P2_BTN2  = 8'h1B;
    localparam logic [7:0] SC_P2_BTN3  = 8'h15;
    localparam logic [7:0] SC_P2_START = 8'h1E;
    localparam logic [7:0] SC_P2_COIN  = 8'h36;

    localparam logic [7:0] SC_SERVICE1 = 8'h46;
    localparam logic [7:0] SC_SERVICE2 = 8'h45;

    typedef struct packed {
        logic       toggle;
        logic       pressed;
        logic       extended;
        logic [7:0] code;
    } ps2_key_t;

    typedef struct packed {
        logic                   up;
        logic                   down;
        logic                   left;
        logic                   right;
        logic [KBD_BUTTONS-1:0] btn;
        logic                   start;
        logic                   coin;
        logic                   pause;
    } kbd_player_t;

    function automatic int joy_start_idx(input int nb);
        return JOY_BTN_BASE + nb;
    endfunction

    function automatic int joy_coin_idx(input int nb);
        return JOY_BTN_BASE + nb + 1;
    endfunction

    function automatic int joy_pause_idx(input int nb);
        return JOY_BTN_BASE + nb + 2;
    endfunction

endpackage

// File: rtl/input_mapper_if.sv
// Host-side bundle of the input mapper: hps_io inputs in, per-player controls out.
// autofire_mask exists only when INPUT_MAPPER_AUTOFIRE_EN is defined.
interface input_mapper_if #(
    parameter int NUM_PLAYERS = 2,
    parameter int NUM_BUTTONS = 3,
    parameter int JOY_W       = 11
);

    logic [10:0]                      ps2_key;
    logic                             kbd_clear;
    logic [NUM_PLAYERS*JOY_W-1:0]     joystick;
`ifdef INPUT_MAPPER_AUTOFIRE_EN
    logic [NUM_BUTTONS-1:0]           autofire_mask;
`endif
    logic [NUM_PLAYERS*4-1:0]         p_dir;
    logic [NUM_PLAYERS*NUM_BUTTONS-1:0] p_buttons;
    logic [NUM_PLAYERS-1:0]           p_start;
    logic [NUM_PLAYERS-1:0]           p_coin;
    logic [NUM_PLAYERS-1:0]           p_pause;
    logic [1:0]                       service;

    modport master (
`ifdef INPUT_MAPPER_AUTOFIRE_EN
        output autofire_mask,
`endif
        output ps2_key, kbd_clear, joystick,
        input  p_dir, p_buttons, p_start, p_coin, p_pause, service
    );

    modport slave (
`ifdef INPUT_MAPPER_AUTOFIRE_EN
        input  autofire_mask,
`endif
        input  ps2_key, kbd_clear, joystick,
        output p_dir, p_buttons, p_start, p_coin, p_pause, service
    );

endinterface

// File: rtl/input_mapper_coin_stretch.sv
// Coin pulse stretcher: holds the registered coin output high for at least
// COIN_MIN_CYCLES cycles after each rising edge of the raw coin request.
module coin_stretch #(
    parameter logic [15:0] COIN_MIN_CYCLES = 16'd50000
) (
    input  logic clk_sys,
    input  logic RESET,
    input  logic raw_i,
    output logic coin_o
);

    localparam int CNT_W = (COIN_MIN_CYCLES == 16'd0) ? 1 : $clog2(int'(COIN_MIN_CYCLES) + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(COIN_MIN_CYCLES);

    logic             raw_q;
    logic             coin_q, coin_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // NOTE: every signal driven from always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (raw_i && !raw_q) begin
            cnt_d = CNT_LOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        coin_d = raw_i | (cnt_q != '0);
    end

    // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            raw_q  <= 1'b0;
            cnt_q  <= '0;
            coin_q <= 1'b0;
        end else begin
            raw_q  <= raw_i;
            cnt_q  <= cnt_d;
            coin_q <= coin_d;
        end
    end

    assign coin_o = coin_q;

endmodule

// File: rtl/input_mapper.sv
// Player-input front end: decodes PS/2 key events into held keys, merges them with
// hps_io joystick words and registers per-player controls. Optional: INPUT_MAPPER_AUTOFIRE_EN.
module input_mapper
    import input_mapper_pkg::*;
#(
    parameter int          NUM_PLAYERS          = 2,
    parameter int          NUM_BUTTONS          = 3,
    parameter int          JOY_W                = 11,
    parameter logic [15:0] COIN_MIN_CYCLES      = 16'd50000,
    parameter logic [23:0] AUTOFIRE_HALF_PERIOD = 24'd1000000
) (
    input logic           clk_sys,
    input logic           RESET,
    input_mapper_if.slave mapper
);

    ps2_key_t                      ps2;
    logic                          primed_q;
    logic                          last_toggle_q;
    logic                          key_event;
    kbd_player_t [KBD_PLAYERS-1:0] kbd_q, kbd_d;
    logic [1:0]                    svc_q, svc_d;
    logic [1:0]                    service_q;
    logic [NUM_BUTTONS-1:0]        af_gate;
    logic                          unused_ext;

    assign ps2        = ps2_key_t'(mapper.ps2_key);
    assign unused_ext = ps2.extended;

    // The first edge after reset only samples the toggle bit, so a toggle already high is not an event.
    assign key_event = primed_q && (ps2.toggle != last_toggle_q);

    always_comb begin
        kbd_d = kbd_q;
        svc_d = svc_q;
        if (mapper.kbd_clear) begin
            kbd_d = '0;
            svc_d = '0;
        end else if (key_event) begin
            case (ps2.code)
                SC_P1_UP:    kbd_d[0].up     = ps2.pressed;
                SC_P1_DOWN:  kbd_d[0].down   = ps2.pressed;
                SC_P1_LEFT:  kbd_d[0].left   = ps2.pressed;
                SC_P1_RIGHT: kbd_d[0].right  = ps2.pressed;
                SC_P1_BTN1:  kbd_d[0].btn[0] = ps2.pressed;
                SC_P1_BTN2:  kbd_d[0].btn[1] = ps2.pressed;
                SC_P1_BTN3:  kbd_d[0].btn[2] = ps2.pressed;
                SC_P1_START: kbd_d[0].start  = ps2.pressed;
                SC_P1_COIN:  kbd_d[0].coin   = ps2.pressed;
                SC_P1_PAUSE: kbd_d[0].pause  = ps2.pressed;
                SC_P2_UP:    kbd_d[1].up     = ps2.pressed;
                SC_P2_DOWN:  kbd_d[1].down   = ps2.pressed;
                SC_P2_LEFT:  kbd_d[1].left   = ps2.pressed;
                SC_P2_RIGHT: kbd_d[1].right  = ps2.pressed;
                SC_P2_BTN1:  kbd_d[1].btn[0] = ps2.pressed;
                SC_P2_BTN2:  kbd_d[1].btn[1] = ps2.pressed;
                SC_P2_BTN3:  kbd_d[1].btn[2] = ps2.pressed;
                SC_P2_START: kbd_d[1].start  = ps2.pressed;
                SC_P2_COIN:  kbd_d[1].coin   = ps2.pressed;
                SC_SERVICE1: svc_d[0]        = ps2.pressed;
                SC_SERVICE2: svc_d[1]        = ps2.pressed;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            primed_q      <= 1'b0;
            last_toggle_q <= 1'b0;
            kbd_q         <= '0;
            svc_q         <= '0;
            service_q     <= '0;
        end else begin
            primed_q      <= 1'b1;
            last_toggle_q <= ps2.toggle;
            kbd_q         <= kbd_d;
            svc_q         <= svc_d;
            service_q     <= svc_q;
        end
    end

    assign mapper.service = service_q;

`ifdef INPUT_MAPPER_AUTOFIRE_EN
    logic [23:0] af_cnt_q;
    logic        af_phase_q;

    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            af_cnt_q   <= '0;
            af_phase_q <= 1'b0;
        end else if (af_cnt_q == AUTOFIRE_HALF_PERIOD - 24'd1) begin
            af_cnt_q   <= '0;
            af_phase_q <= ~af_phase_q;
        end else begin
            af_cnt_q   <= af_cnt_q + 24'd1;
        end
    end

    assign af_gate = ~mapper.autofire_mask | {NUM_BUTTONS{af_phase_q}};
`else
    localparam logic [23:0] unused_af_half = AUTOFIRE_HALF_PERIOD;
    assign af_gate = '1;
`endif

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        logic [JOY_W-1:0]       joy;
        kbd_player_t            kbd;
        logic [NUM_BUTTONS-1:0] kbd_btn;
        logic [3:0]             dir_d, dir_q;
        logic [NUM_BUTTONS-1:0] btn_d, btn_q;
        logic                   start_d, start_q;
        logic                   pause_d, pause_q;
        logic                   coin_raw, coin_out;
        logic                   unused_kbd_btn;

        assign joy            = mapper.joystick[p*JOY_W +: JOY_W];
        assign unused_kbd_btn = ^kbd.btn;

        if (p < KBD_PLAYERS) begin : g_kbd
            assign kbd = kbd_q[p];
        end else begin : g_no_kbd
            assign kbd = '0;
        end

        // Buttons past the keyboard map are driven by the joystick alone.
        for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
            if (i < KBD_BUTTONS) begin : g_mapped
                assign kbd_btn[i] = kbd.btn[i];
            end else begin : g_joy_only
                assign kbd_btn[i] = 1'b0;
            end
        end

        if (JOY_W > NUM_BUTTONS + 7) begin : g_spare
            logic unused_joy;
            assign unused_joy = ^joy[JOY_W-1:NUM_BUTTONS+7];
        end

        assign dir_d    = joy[3:0] | {kbd.up, kbd.down, kbd.left, kbd.right};
        assign btn_d    = (joy[JOY_BTN_BASE +: NUM_BUTTONS] | kbd_btn) & af_gate;
        assign start_d  = joy[joy_start_idx(NUM_BUTTONS)] | kbd.start;
        assign pause_d  = joy[joy_pause_idx(NUM_BUTTONS)] | kbd.pause;
        assign coin_raw = joy[joy_coin_idx(NUM_BUTTONS)]  | kbd.coin;

        always_ff @(posedge clk_sys or posedge RESET) begin
            if (RESET) begin
                dir_q   <= '0;
                btn_q   <= '0;
                start_q <= 1'b0;
                pause_q <= 1'b0;
            end else begin
                dir_q   <= dir_d;
                btn_q   <= btn_d;
                start_q <= start_d;
                pause_q <= pause_d;
            end
        end

        coin_stretch #(
            .COIN_MIN_CYCLES(COIN_MIN_CYCLES)
        ) u_coin (
            .clk_sys(clk_sys),
            .RESET  (RESET),
            .raw_i  (coin_raw),
            .coin_o (coin_out)
        );

        assign mapper.p_dir[p*4 +: 4]                       = dir_q;
        assign mapper.p_buttons[p*NUM_BUTTONS +: NUM_BUTTONS] = btn_q;
        assign mapper.p_start[p]                            = start_q;
        assign mapper.p_pause[p]                            = pause_q;
        assign mapper.p_coin[p]                             = coin_out;
    end

endmodule

// File: doc/input_mapper.md
Name: input_mapper

Overview:
- Parametrised player-input front end in the clk_sys domain; successor to the fixed two-player keyboard/joystick merge in the emu top level.
- Decodes hps_io PS/2 key events into held-key state and merges them with per-player joystick words.
- Stretches coin pulses to a guaranteed minimum width and delivers registered, per-player control vectors to Main.

Parameters:
- NUM_PLAYERS, 2, number of player slots (1..4); only players 0 and 1 have keyboard mappings.
- NUM_BUTTONS, 3, fire buttons per player (1..6).
- JOY_W, 11, width of each hps_io joystick word; must be >= NUM_BUTTONS+7.
- COIN_MIN_CYCLES, 16'd50000, minimum coin-high width in clk_sys cycles; 0 disables stretching.
- AUTOFIRE_HALF_PERIOD, 24'd1000000, autofire phase half-period in clk_sys cycles; used only with AUTOFIRE_EN.

Ports:
- clk_sys  in  1  system clock
- RESET  in  1  asynchronous, active-high reset
- ps2_key  in  11  hps_io key event: [10] toggle, [9] pressed, [8] extended, [7:0] scancode
- kbd_clear  in  1  synchronous clear of all held-key state (OSD open / focus loss)
- joystick  in  NUM_PLAYERS*JOY_W  concatenated joystick words, player 0 in LSBs
- autofire_mask  in  NUM_BUTTONS  per-button autofire enable; present only with AUTOFIRE_EN
- p_dir  out  NUM_PLAYERS*4  per player {up,down,left,right}
- p_buttons  out  NUM_PLAYERS*NUM_BUTTONS  per player, button 1 in LSB
- p_start  out  NUM_PLAYERS  start
- p_coin  out  NUM_PLAYERS  stretched coin
- p_pause  out  NUM_PLAYERS  pause
- service  out  2  service 1/2 (keys 9/0)

Behaviour:
- Reset: every output, key register, coin counter and the autofire phase = 0; primed flag = 0.
- Priming: on the first clk_sys edge after RESET deasserts, sample ps2_key[10] into last_toggle with no decode, then set primed. This suppresses a spurious event when the toggle bit is already 1.
- Event decode: when primed and ps2_key[10] != last_toggle, the mapped key register takes ps2_key[9] on that edge; last_toggle updates every edge.
- Key matching ignores ps2_key[8]. Unmapped codes have no effect. Buttons beyond the keyboard map (button index >= 3) are joystick-only.
- kbd_clear: all key registers go to 0 on that edge. If an event arrives on the same edge, clear wins and the event is dropped.
- Joystick bit layout per word: [0] right, [1] left, [2] down, [3] up, [4+i] button i, [4+NB] start, [5+NB] coin, [6+NB] pause. Bits >= 7+NB are ignored.
- Merge: raw = key OR joystick bit.
- Output register: all outputs are registered. A key event becomes visible on outputs 2 edges after the toggle change is sampled; a joystick change becomes visible after 1 edge.
- Coin stretch, per player, counter width $clog2(COIN_MIN_CYCLES+1):
  - Rising edge of raw coin loads COIN_MIN_CYCLES.
  - Otherwise the counter decrements while nonzero.
  - p_coin = raw_coin | (cnt != 0).
  - A new rising edge during a pulse reloads the counter (retrigger).
  - A counter at 0 with raw held high keeps p_coin high.
- RESET mid-pulse: counters go to 0 immediately and asynchronously, and p_coin = 0.
- Player 2 has no keyboard pause; service outputs come from keyboard only.

Optional Feature:
- Macro: INPUT_MAPPER_AUTOFIRE_EN.
- Defined:
  - Adds the autofire_mask port, a shared 24-bit phase counter and a phase bit.
  - The phase bit toggles every AUTOFIRE_HALF_PERIOD cycles.
  - For each masked button: output = raw & phase.
  - Phase resets to 0, so the first AUTOFIRE_HALF_PERIOD cycles of a held masked button read 0.
- Undefined: no port, no counter; buttons pass through unchanged.

Decomposition:
- Package input_mapper_pkg holds:
  - Scancode constants: P1 up 8'h75, down 8'h72, left 8'h6B, right 8'h74, buttons 8'h14/8'h11/8'h29, start 8'h16, coin 8'h2E, pause 8'h4D.
  - P2 up 8'h2D, down 8'h2B, left 8'h23, right 8'h34, buttons 8'h1C/8'h1B/8'h15, start 8'h1E, coin 8'h36.
  - Service 8'h46/8'h45.
  - Joystick bit-index functions (start/coin/pause index from NB).
- Sub-module coin_stretch (parameter COIN_MIN_CYCLES), instantiated once per player.

Test Plan:
- Priming: hold ps2_key[10]=1 through reset, release, keep stable -> no key change; then toggle to 0 with {pressed=1, code 8'h75} -> p_dir[3]=1 exactly 2 edges later; toggle with pressed=0 -> returns to 0.
- Keyboard/joystick merge: key 8'h14 held; joystick[4]=1, then joystick[4]=0 -> p_buttons[0] stays 1 until key released. Extended flag set on 8'h75 still drives up.
- Coin stretch (COIN_MIN_CYCLES=8): 1-cycle joystick[8] pulse -> p_coin[0] high exactly 9 cycles. Retrigger at cycle 5 -> high until 8 cycles after the retrigger.
- Reset mid-pulse: assert RESET at count 4 -> p_coin immediately 0; after release, no residual pulse.
- kbd_clear coincident with a press event of 8'h16 -> p_start[0]=0. Earlier held 8'h2D is cleared too.
- AUTOFIRE_EN, AUTOFIRE_HALF_PERIOD=4, mask=3'b001, button 1 held -> p_buttons[0] period-8 square wave; button 2 held steady.
